pattern_mem_writer: RTL
=======================

# pattern_mem_writer

Serial-to-parallel loader that builds the 9-entry, 8-bit pattern memory scanned by the window-matching datapath. It accepts a bit stream under a valid/ready handshake, packs bits MSB-first into bytes, and writes each byte into consecutive memory locations. The matcher and its control unit read the same memory through a combinational read port. The block raises `full` when all entries are loaded.

## Interface
Parameters:
- `WIDTH`, 8: bits per memory word.
- `DEPTH`, 9: number of memory words.
- `ADDR_W`, 4: address width; must satisfy 2^ADDR_W ≥ DEPTH.

Ports:
- `clk` input 1: single clock; all state changes on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `start` input 1: synchronous; clears the write pointer and begins or restarts a load.
- `din` input 1: serial data bit.
- `din_valid` input 1: `din` is valid this cycle.
- `ready` output 1: the block accepts a bit this cycle.
- `rd_addr` input ADDR_W: read address used by the matcher and control unit.
- `rd_data` output WIDTH: combinational equal to `mem[rd_addr]`; 0 when `rd_addr` ≥ DEPTH.
- `wr_en` output 1: registered; high for one cycle while a word is written.
- `wr_addr` output ADDR_W: registered write pointer, which is also the target of the next write.
- `word_count` output ADDR_W: number of words written since the last `start`.
- `busy` output 1: high in SHIFT and WRITE.
- `full` output 1: high in FULL.

## Operation
- States are IDLE, SHIFT, WRITE and FULL.
- Reset values:
  - State: IDLE.
  - `ready`, `wr_en`, `busy`, `full`: 0.
  - `wr_addr`, `word_count`, bit counter, shift register: 0.
  - All memory words: 0.
- IDLE:
  - `ready`=0.
  - `start` → SHIFT, with pointer = 0, bit counter = 0, shift register = 0.
- SHIFT:
  - `ready`=1.
  - A bit is accepted when `din_valid` && `ready`: `shreg <= {shreg[WIDTH-2:0], din}` and the bit counter increments.
  - When the accepted bit is the WIDTH-th bit (bit counter = WIDTH-1), go to WRITE.
  - The first bit received lands in the word's MSB.
- WRITE, which lasts exactly one cycle:
  - `ready`=0 and `wr_en`=1.
  - `mem[wr_addr] <= shreg` at the end of the cycle.
  - The pointer and `word_count` increment and the bit counter clears.
  - If the incremented pointer equals DEPTH → FULL; otherwise → SHIFT.
- FULL:
  - `ready`=0.
  - `din_valid` is ignored.
  - `wr_addr` holds DEPTH and `word_count`=DEPTH.
  - Only `start` leaves FULL.
- A bit presented while `ready`=0 is dropped. There is no buffering and no error flag.
- `start` has priority in every state:
  - Next state is SHIFT, with pointer, `word_count`, bit counter and shift register cleared.
  - A partial word or a pending WRITE is discarded, so `wr_en` stays 0 that cycle's successor.
  - Memory contents are retained and overwritten by later writes.
- Width rules:
  - The bit counter is ceil(log2(WIDTH)) bits.
  - The pointer never exceeds DEPTH and never wraps.

## Timing
- The last bit of a word is accepted at edge N. `wr_en`=1 during cycle N+1 and memory updates at edge N+1.
- `rd_data` reflects the new word from cycle N+2. `word_count` and `wr_addr` increment at edge N+1.
- Throughput: one word per WIDTH+1 cycles at most, because of the single WRITE bubble.
- `full` rises in the cycle after the DEPTH-th WRITE cycle.
- `rd_data` has zero-cycle latency from `rd_addr`. A read of the location being written in WRITE returns the old value.
- `rst` asserted mid-word or mid-WRITE:
  - All outputs and memory go to their reset values immediately, without waiting for a clock edge.
  - The write in progress does not happen.

## Test plan
- **Reset values:** assert `rst` → `ready`=0, `busy`=0, `full`=0, `wr_en`=0, `word_count`=0; `rd_data`=0 for `rd_addr` 0..8.
- **Single word:** `start`, then bits 1,0,1,0,0,1,1,1 with `din_valid` held high → `wr_en` pulses one cycle with `wr_addr`=0; `rd_addr`=0 gives `rd_data`=0xA7; `word_count`=1; `ready` is low exactly one cycle.
- **Fill and overflow:**
  - Load 9 words 0x00..0x08 → `full`=1, `word_count`=9, `ready`=0, and `rd_data`==n at `rd_addr`=n.
  - A further 8 valid bits leave memory and counters unchanged.
  - `rd_addr`=12 → `rd_data`=0.
- **Start mid-word:**
  - Load word 0xFF, then 4 bits of the next word, then pulse `start` → `word_count`=0, `wr_addr`=0, no `wr_en`.
  - Then load 0x3C → `mem[0]`=0x3C.
- **Handshake drop:** present a valid bit during the WRITE cycle → it is dropped, and the next word assembles only from bits accepted afterwards.
- **Async reset mid-operation:** assert `rst` between clock edges during SHIFT after 5 bits → state resets immediately; after `start` and a full byte 0x81, `mem[0]`=0x81 and no stale bits appear.

Source files
------------

// File: rtl/pattern_mem_writer.sv
// pattern_mem_writer: packs a serial bit stream MSB-first into bytes and
// writes them into consecutive words of a small pattern memory. The memory
// has a combinational read port for the window matcher and its control unit.
module pattern_mem_writer #(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 9,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              din,
    input  logic              din_valid,
    output logic              ready,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [ADDR_W-1:0] word_count,
    output logic              busy,
    output logic              full
);

    localparam int BIT_CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [BIT_CNT_W-1:0] LAST_BIT  = BIT_CNT_W'(WIDTH - 1);
    localparam logic [ADDR_W-1:0]    LAST_ADDR = ADDR_W'(DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        WRITE,
        FULL
    } state_t;

    state_t                 state_reg, state_next;
    logic [ADDR_W-1:0]      wr_addr_reg, wr_addr_next;
    logic [BIT_CNT_W-1:0]   bit_cnt_reg, bit_cnt_next;
    logic [WIDTH-1:0]       shreg_reg, shreg_next;
    logic                   mem_we;
    logic [WIDTH-1:0]       mem_reg [DEPTH];

    // Handshake and status flags are plain decodes of the state register.
    assign ready      = (state_reg == SHIFT);
    assign wr_en      = (state_reg == WRITE);
    assign busy       = (state_reg == SHIFT) || (state_reg == WRITE);
    assign full       = (state_reg == FULL);
    assign wr_addr    = wr_addr_reg;
    // The pointer only moves on a completed write, so it doubles as the word count.
    assign word_count = wr_addr_reg;

    // State, pointer, bit counter and shift register; async reset clears all.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= IDLE;
            wr_addr_reg <= '0;
            bit_cnt_reg <= '0;
            shreg_reg   <= '0;
        end else begin
            state_reg   <= state_next;
            wr_addr_reg <= wr_addr_next;
            bit_cnt_reg <= bit_cnt_next;
            shreg_reg   <= shreg_next;
        end
    end

    // Next-state logic; start overrides everything, including a pending write.
    always_comb begin
        state_next   = state_reg;
        wr_addr_next = wr_addr_reg;
        bit_cnt_next = bit_cnt_reg;
        shreg_next   = shreg_reg;
        mem_we       = 1'b0;
        if (start) begin
            state_next   = SHIFT;
            wr_addr_next = '0;
            bit_cnt_next = '0;
            shreg_next   = '0;
        end else begin
            case (state_reg)
                IDLE: begin
                end
                SHIFT: begin
                    if (din_valid) begin
                        shreg_next   = {shreg_reg[WIDTH-2:0], din};
                        bit_cnt_next = bit_cnt_reg + 1'b1;
                        if (bit_cnt_reg == LAST_BIT) begin
                            state_next = WRITE;
                        end
                    end
                end
                WRITE: begin
                    mem_we       = 1'b1;
                    wr_addr_next = wr_addr_reg + 1'b1;
                    bit_cnt_next = '0;
                    state_next   = (wr_addr_reg == LAST_ADDR) ? FULL : SHIFT;
                end
                FULL: begin
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    // Pattern memory: flops so reset can clear every word asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_reg[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (mem_we && (wr_addr_reg == ADDR_W'(i))) begin
                    mem_reg[i] <= shreg_reg;
                end
            end
        end
    end

    // Combinational read port; addresses beyond the last word read as zero.
    always_comb begin
        rd_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (rd_addr == ADDR_W'(i)) begin
                rd_data = mem_reg[i];
            end
        end
    end

endmodule
